// File: rtl/enc_pkg.sv
//==============================================================================
// enc_pkg: shared types, default sizes and popcount helper for event_encoder_8x3
// Revision: 1.0
//==============================================================================
`default_nettype none

package enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int WIDTH_DEF   = 8;
    localparam int CODE_W_DEF  = 3;
    localparam int POP_MAX_W   = 256;

    // Sized for the widest legal request vector; callers zero-extend.
    function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_prio_pick.sv
//==============================================================================
// onehot_prio_pick: combinational find-first-set starting at i_start, wrapping
// Revision: 1.0
//==============================================================================
`default_nettype none

module onehot_prio_pick #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  i_vec,
    input  logic [CODE_W-1:0] i_start,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_found
);

    logic [CODE_W-1:0] w_idx;

    // Scan from the far end so the offset nearest i_start is assigned last.
    // Index arithmetic wraps naturally because WIDTH is a power of two.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            w_idx = CODE_W'(k) + i_start;
            if (i_vec[w_idx]) begin
                o_idx   = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_encoder_8x3.sv
//==============================================================================
// event_encoder_8x3: latches event requests, emits one index per valid/ready.
// Optional ROUND_ROBIN_EN selects rotating priority instead of lowest-first.
// Revision: 1.0
//==============================================================================
`default_nettype none

module event_encoder_8x3
    import enc_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CODE_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  req,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [CODE_W:0]   pend_cnt,
    output logic              drop
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_pend;
    logic [CODE_W-1:0] r_code;
    logic              r_drop;
    logic [CODE_W-1:0] w_start;
    logic [CODE_W-1:0] w_pick;
    logic              w_found;
    logic              w_grant;
    logic [WIDTH-1:0]  w_clr;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_pick + CODE_W'(1);
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    onehot_prio_pick #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_pick (
        .i_vec   (r_pend),
        .i_start (w_start),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    // The register already has the held code's bit cleared, so searching it
    // directly picks up only other events or a genuine re-request.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_found) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr = w_grant ? (WIDTH'(1) << w_pick) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_code  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= (r_pend & ~w_clr) | req;
            r_drop  <= |(req & r_pend & ~w_clr);
            if (w_grant) begin
                r_code <= w_pick;
            end
        end
    end

    assign out_valid = (r_state == HOLD);
    assign out_code  = r_code;
    assign drop      = r_drop;
    assign pend_cnt  = (CODE_W + 1)'(popcount(POP_MAX_W'(r_pend)));

endmodule

`default_nettype wire

// File: tb/tb_event_encoder_8x3.sv
//==============================================================================
// tb_event_encoder_8x3: vector table, directed corner cases and random traffic
// checked against a behavioural model of the event encoder.
//==============================================================================
`default_nettype none

module tb_event_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [3:0] pend_cnt;
    logic       drop;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [7:0] m_pend;
    bit       m_valid;
    bit [2:0] m_code;
    bit       m_drop;
    int       m_rr;

    typedef struct {
        bit [7:0] req;
        bit       rdy;
        bit       valid;
        bit [2:0] code;
        bit [3:0] cnt;
        bit       drop;
    } vec_t;

    vec_t tbl [12];

    event_encoder_8x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pend_cnt  (pend_cnt),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int count_ones(input bit [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int pick(input bit [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = '0;
        m_drop  = 1'b0;
        m_rr    = 0;
    endtask

    // Drive one cycle, advance the model with the spec's rules, compare.
    task automatic step(input bit [7:0] r, input bit rdy);
        bit       acc;
        bit       g;
        int       p;
        int       start;
        bit [7:0] clr;
        bit [7:0] n_pend;
        bit       n_drop;
        bit       n_valid;
        bit [2:0] n_code;
        int       n_rr;
        req       = r;
        out_ready = rdy;
`ifdef ROUND_ROBIN_EN
        start = m_rr;
`else
        start = 0;
`endif
        acc     = m_valid && rdy;
        p       = pick(m_pend, start);
        g       = (!m_valid || acc) && (p >= 0);
        clr     = g ? (8'd1 << p) : 8'd0;
        n_drop  = |(r & m_pend & ~clr);
        n_pend  = (m_pend & ~clr) | r;
        n_valid = g ? 1'b1 : (acc ? 1'b0 : m_valid);
        n_code  = g ? 3'(p) : m_code;
        n_rr    = g ? (p + 1) % 8 : m_rr;
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_drop  = n_drop;
        m_valid = n_valid;
        m_code  = n_code;
        m_rr    = n_rr;
        chk("model_valid", int'(out_valid), int'(m_valid));
        chk("model_code", int'(out_code), int'(m_code));
        chk("model_drop", int'(drop), int'(m_drop));
        chk("model_cnt", int'(pend_cnt), count_ones(m_pend));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //            req         rdy  valid code cnt drop
        tbl[0]  = '{8'b0010_0100, 1'b1, 1'b0, 3'd0, 4'd2, 1'b0};
        tbl[1]  = '{8'h00,        1'b1, 1'b1, 3'd2, 4'd1, 1'b0};
        tbl[2]  = '{8'h00,        1'b1, 1'b1, 3'd5, 4'd0, 1'b0};
        tbl[3]  = '{8'h00,        1'b1, 1'b0, 3'd5, 4'd0, 1'b0};
        tbl[4]  = '{8'h80,        1'b0, 1'b0, 3'd5, 4'd1, 1'b0};
        tbl[5]  = '{8'h00,        1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        tbl[6]  = '{8'h00,        1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        tbl[7]  = '{8'h00,        1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        tbl[8]  = '{8'h00,        1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        tbl[9]  = '{8'h00,        1'b0, 1'b1, 3'd7, 4'd0, 1'b0};
        tbl[10] = '{8'h00,        1'b1, 1'b0, 3'd7, 4'd0, 1'b0};
        tbl[11] = '{8'h00,        1'b1, 1'b0, 3'd7, 4'd0, 1'b0};

        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_code", int'(out_code), 0);
        chk("reset_cnt", int'(pend_cnt), 0);
        chk("reset_drop", int'(drop), 0);
        rst_n = 1'b1;

        // Multi-hot and backpressure vectors
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].valid));
            chk($sformatf("vec%0d_code", i), int'(out_code), int'(tbl[i].code));
            chk($sformatf("vec%0d_cnt", i), int'(pend_cnt), int'(tbl[i].cnt));
            chk($sformatf("vec%0d_drop", i), int'(drop), int'(tbl[i].drop));
        end

        // Merge: second bit3 request while bit3 still pending behind code 7
        step(8'h80, 1'b0);
        step(8'h00, 1'b0);
        step(8'h08, 1'b0);
        chk("merge_first_drop", int'(drop), 0);
        step(8'h00, 1'b0);
        step(8'h08, 1'b0);
        chk("merge_drop_pulse", int'(drop), 1);
        step(8'h00, 1'b0);
        chk("merge_drop_clear", int'(drop), 0);
        chk("merge_hold_code", int'(out_code), 7);
        step(8'h00, 1'b1);
        chk("merge_code3", int'(out_code), 3);
        chk("merge_valid3", int'(out_valid), 1);
        step(8'h00, 1'b1);
        chk("merge_done_valid", int'(out_valid), 0);
        step(8'h00, 1'b1);
        chk("merge_no_reemit", int'(out_valid), 0);

        // Set-wins: bit4 re-requested on the cycle code 4 is loaded
        step(8'h10, 1'b0);
        step(8'h10, 1'b0);
        chk("setwin_code", int'(out_code), 4);
        chk("setwin_drop", int'(drop), 0);
        chk("setwin_repend", int'(pend_cnt), 1);
        step(8'h00, 1'b1);
        chk("setwin_second_valid", int'(out_valid), 1);
        chk("setwin_second_code", int'(out_code), 4);
        step(8'h00, 1'b1);
        chk("setwin_end_valid", int'(out_valid), 0);

        // Priority with 8'h81 held
        reset_dut();
        step(8'h81, 1'b1);
        chk("prio_lat_valid", int'(out_valid), 0);
        for (int k = 0; k < 6; k++) begin
            int exp_code;
`ifdef ROUND_ROBIN_EN
            exp_code = (k % 2 == 1) ? 7 : 0;
`else
            exp_code = 0;
`endif
            step(8'h81, 1'b1);
            chk($sformatf("prio_valid%0d", k), int'(out_valid), 1);
            chk($sformatf("prio_code%0d", k), int'(out_code), exp_code);
        end

        // Random traffic against the model
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            bit [7:0] r;
            bit       rdy;
            r   = 8'($urandom & $urandom & $urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy);
        end

        // Asynchronous reset in the middle of HOLD with everything pending
        reset_dut();
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        chk("midreset_pre_valid", int'(out_valid), 1);
        chk("midreset_pre_cnt", int'(pend_cnt), 8);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("midreset_valid", int'(out_valid), 0);
        chk("midreset_code", int'(out_code), 0);
        chk("midreset_cnt", int'(pend_cnt), 0);
        chk("midreset_drop", int'(drop), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 1'b1);
            chk($sformatf("postreset_idle%0d", k), int'(out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
